packet_lock_arbiter: RTL and testbench
======================================

Name: packet_lock_arbiter

Overview:
- Multi-flit packet arbiter that shares one datapath output port among NUM_REQ input channels.
- Uses lowest-index-first fixed priority, or a forced single-channel mode (arb_enable=0, channel chosen by single_mask).
- Locks the grant for a whole packet and registers the output through a one-entry buffer with valid/ready backpressure.
- Sits in front of each router/datapath output, sequencing packets from the fixed-priority request set into a single stream.

Parameters:
- NUM_REQ, 4, number of input channels (≥2).
- DATA_WIDTH, 64, flit width in bits.
- MAX_FLITS, 256, maximum flits per packet before forced release (≥2).
- SRC_W, $clog2(NUM_REQ), width of out_src (localparam).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- arb_enable  input  1  1 = priority arbitration over all channels; 0 = single-channel mode.
- single_mask  input  NUM_REQ  channel selection used when arb_enable=0.
- in_valid  input  NUM_REQ  per-channel flit valid.
- in_last  input  NUM_REQ  per-channel end-of-packet flag, qualified by in_valid.
- in_data  input  NUM_REQ*DATA_WIDTH  channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  NUM_REQ  per-channel accept.
- out_valid  output  1  output flit valid (registered).
- out_ready  input  1  downstream accept.
- out_data  output  DATA_WIDTH  registered flit.
- out_last  output  1  registered end-of-packet flag.
- out_src  output  SRC_W  index of the source channel of the current out flit.
- busy  output  1  high while in LOCK.
- len_err  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async assert, sync deassert by clk): state=IDLE; grant_q=0; flit_cnt=0.
- Reset values: out_valid=0, out_data=0, out_last=0, out_src=0, busy=0, len_err=0, in_ready=0.
- eligible = arb_enable ? in_valid : (in_valid & single_mask).
- winner = lowest set bit of eligible; ties always go to the lower index.
- arb_enable and single_mask are sampled only in IDLE. Changes during LOCK are ignored until release.
- IDLE:
  - in_ready=0.
  - If eligible≠0: grant_q<=winner, flit_cnt<=0, state<=LOCK.
  - Otherwise stay in IDLE.
- LOCK:
  - busy=1.
  - slot_free = !out_valid | out_ready.
  - in_ready = grant_q & {NUM_REQ{slot_free}}, combinational.
  - Transfer occurs when in_valid[g] & in_ready[g], where g = granted index.
  - On transfer: out_data<=in_data[g], out_last<=in_last[g], out_src<=g, out_valid<=1, flit_cnt<=flit_cnt+1.
  - No transfer and out_ready=1: out_valid<=0.
  - out_valid=1 and out_ready=0: out_* hold stable.
  - Release on a transfer with in_last[g]=1: state<=IDLE, grant_q<=0.
  - Forced release on a transfer where flit_cnt==MAX_FLITS-1 and in_last[g]=0:
    - state<=IDLE, grant_q<=0, len_err<=1 for exactly one cycle.
    - out_last is forced to 1 on that flit.
- Latency:
  - in_valid rises in IDLE at cycle t → in_ready at t+1 (if slot free) → out_valid at t+2.
  - Steady state: one flit per cycle with out_ready held high.
  - One idle bubble cycle between packets, spent re-arbitrating in IDLE.
- Non-granted channels see in_ready=0 throughout a lock. A higher-priority request arriving mid-packet does not preempt.
- Granted channel dropping in_valid mid-packet: stay locked, wait indefinitely.
- Single-channel mode:
  - single_mask with multiple bits set → lowest set bit of (in_valid & single_mask) wins.
  - single_mask=0 → eligible=0, no grant.
- flit_cnt is clog2(MAX_FLITS) bits wide, saturates at no point (cleared on lock), and never wraps within a packet.
- Output buffer drains independently of state. IDLE with out_valid=1 and out_ready=1 → out_valid<=0.
- Reset asserted mid-packet: immediate return to reset values. The partially sent packet is not completed; upstream must re-send.

Test Plan:
- Priority: in_valid=4'b1010, each sends 3-flit packet, arb_enable=1, out_ready=1.
  → ch1 packet out_src=1 (3 flits, last on 3rd), 1 bubble, then ch3 out_src=3.
  → in_ready[3]=0 throughout ch1 lock.
- No preemption: ch2 locked mid 4-flit packet, ch0 raises in_valid.
  → ch2 completes all 4 flits before ch0 granted; ch0 flit appears 2 cycles after ch2 last leaves IDLE.
- Single mode: arb_enable=0, single_mask=4'b0100, in_valid=4'b0111.
  → only ch2 granted.
  → single_mask=4'b1000, in_valid=4'b0111: no grant, busy stays 0.
- Backpressure: 5-flit packet, out_ready toggles 1,0,0,1,…
  → out_data stable while out_ready=0, no flit lost or duplicated, in_ready low when buffer full and out_ready=0.
- Length guard: MAX_FLITS=4, ch0 sends 6 flits without last.
  → 4th flit has out_last=1, len_err pulses one cycle, state returns to IDLE, remaining flits start a new packet.
- Reset mid-packet: rst_n low during flit 2 of 3.
  → out_valid=0, in_ready=0, busy=0 immediately.
  → after release, fresh arbitration with 2-cycle latency.

Source files
------------

// File: rtl/packet_lock_arbiter.sv
// packet_lock_arbiter: shares one output port among NUM_REQ channels.
// Fixed lowest-index priority (or single-channel mode), grant held
// for a whole packet, output registered in a one-entry buffer.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   arb_enable            1 = arbitrate all channels, 0 = single_mask only
//   single_mask           channel filter used when arb_enable = 0
//   in_valid/in_last      per-channel flit valid / end-of-packet
//   in_data               channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready              per-channel accept (granted channel only)
//   out_valid/out_ready   registered output handshake
//   out_data/out_last     registered flit and end-of-packet flag
//   out_src               source channel of the current output flit
//   busy                  high while a packet is locked
//   len_err               one-cycle pulse on forced release
module packet_lock_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int MAX_FLITS  = 256,
    localparam int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_enable,
    input  logic [NUM_REQ-1:0]            single_mask,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ-1:0]            in_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [SRC_W-1:0]              out_src,
    output logic                          busy,
    output logic                          len_err
);

    localparam int CNT_W = $clog2(MAX_FLITS);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]            r_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic [CNT_W-1:0]      r_flit_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic [SRC_W-1:0]      r_out_src;
    logic                  r_len_err;

    logic [NUM_REQ-1:0]    w_elig;
    logic [NUM_REQ-1:0]    w_win;
    logic                  w_lock;
    logic                  w_slot_free;
    logic                  w_gvalid;
    logic                  w_glast;
    logic                  w_xfer;
    logic                  w_at_max;
    logic [DATA_WIDTH-1:0] w_gdata;
    logic [SRC_W-1:0]      w_gidx;

    assign w_elig = arb_enable ? in_valid : (in_valid & single_mask);

    // Two's-complement trick isolates the lowest set bit.
    assign w_win = w_elig & (~w_elig + NUM_REQ'(1));

    assign w_lock      = (r_state == LOCK);
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_gvalid    = |(in_valid & r_grant);
    assign w_glast     = |(in_last & r_grant);
    assign w_xfer      = w_lock && w_slot_free && w_gvalid;
    assign w_at_max    = (r_flit_cnt == CNT_W'(MAX_FLITS - 1));

    // r_grant is one-hot (or zero), so the loop acts as a plain mux.
    always_comb begin
        w_gidx  = '0;
        w_gdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_gidx  = SRC_W'(i);
                w_gdata = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_ready  = (w_lock && w_slot_free) ? r_grant : '0;
    assign busy      = w_lock;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;
    assign len_err   = r_len_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_flit_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
            r_len_err   <= 1'b0;
        end else begin
            r_len_err <= 1'b0;

            // Output buffer drains regardless of arbiter state.
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gdata;
                r_out_last  <= w_glast || w_at_max;
                r_out_src   <= w_gidx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (|w_elig) begin
                        r_grant    <= w_win;
                        r_flit_cnt <= '0;
                        r_state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (w_xfer) begin
                        r_flit_cnt <= r_flit_cnt + CNT_W'(1);
                        if (w_glast || w_at_max) begin
                            r_state   <= IDLE;
                            r_grant   <= '0;
                            r_len_err <= !w_glast;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_lock_arbiter.sv
// Directed bench for packet_lock_arbiter: reactive per-channel sources,
// per-cycle log and output-flit capture checked against hand timelines.
module tb_packet_lock_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MF = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arb_enable;
    logic [N-1:0]  single_mask;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_last;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    out_src;
    logic          busy;
    logic          len_err;

    packet_lock_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_FLITS  (MF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_enable  (arb_enable),
        .single_mask (single_mask),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_src     (out_src),
        .busy        (busy),
        .len_err     (len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            c;
        logic [DW-1:0] d;
        logic          l;
        logic [1:0]    s;
    } ent_t;

    logic [DW:0]   srcq [N][$];
    ent_t          outq [$];
    logic [N-1:0]  lg_ir   [64];
    logic          lg_busy [64];
    logic          lg_ov   [64];
    logic          lg_le   [64];
    logic [DW-1:0] lg_od   [64];
    logic [3:0]    rdy_pat;
    int            cyc;
    int            n_chk;
    int            n_pass;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                in_valid[i]         = 1'b1;
                in_last[i]          = srcq[i][0][DW];
                in_data[i*DW +: DW] = srcq[i][0][DW-1:0];
            end else begin
                in_valid[i]         = 1'b0;
                in_last[i]          = 1'b0;
                in_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic load(input int ch, input logic [DW-1:0] base,
                        input int n, input bit term);
        for (int k = 0; k < n; k++)
            srcq[ch].push_back({(term && k == n - 1), base + DW'(k)});
    endtask

    // One clock cycle: sample mid-cycle, then advance sources after the edge.
    task automatic step();
        logic [N-1:0] fire;
        ent_t e;
        @(negedge clk);
        fire = in_valid & in_ready;
        if (cyc < 64) begin
            lg_ir[cyc]   = in_ready;
            lg_busy[cyc] = busy;
            lg_ov[cyc]   = out_valid;
            lg_le[cyc]   = len_err;
            lg_od[cyc]   = out_data;
        end
        if (out_valid && out_ready) begin
            e.c = cyc;
            e.d = out_data;
            e.l = out_last;
            e.s = out_src;
            outq.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (fire[i]) void'(srcq[i].pop_front());
        drive();
        cyc++;
        out_ready = rdy_pat[cyc % 4];
    endtask

    task automatic restart(input logic ae, input logic [N-1:0] sm,
                           input logic [3:0] pat);
        rst_n    = 1'b0;
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        outq.delete();
        arb_enable  = ae;
        single_mask = sm;
        rdy_pat     = pat;
        out_ready   = pat[0];
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic exp_flit(input string tag, input int idx, input int c,
                            input logic [DW-1:0] d, input logic l,
                            input logic [1:0] s);
        logic [63:0] want;
        logic [63:0] got;
        want = 64'({c[7:0], l, s, d});
        if (idx < outq.size())
            got = 64'({outq[idx].c[7:0], outq[idx].l, outq[idx].s, outq[idx].d});
        else
            got = ~want;
        check(tag, got, want);
    endtask

    function automatic logic any_ir(input int b, input int a, input int z);
        logic r;
        r = 1'b0;
        for (int c = a; c <= z; c++) r = r | lg_ir[c][b];
        return r;
    endfunction

    function automatic logic any_busy(input int a, input int z);
        logic r;
        r = 1'b0;
        for (int c = a; c <= z; c++) r = r | lg_busy[c];
        return r;
    endfunction

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        arb_enable  = 1'b1;
        single_mask = '0;
        in_valid    = '0;
        in_last     = '0;
        in_data     = '0;
        out_ready   = 1'b0;
        rdy_pat     = 4'hF;
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_out_src",   64'(out_src),   64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_len_err",   64'(len_err),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);

        // Priority: ch1 then ch3, one bubble between packets.
        restart(1'b1, 4'b0000, 4'b1111);
        load(1, 16'h1100, 3, 1'b1);
        load(3, 16'h3300, 3, 1'b1);
        drive();
        repeat (12) step();
        check("pri_count", 64'(outq.size()), 64'd6);
        exp_flit("pri_f0", 0, 2, 16'h1100, 1'b0, 2'd1);
        exp_flit("pri_f1", 1, 3, 16'h1101, 1'b0, 2'd1);
        exp_flit("pri_f2", 2, 4, 16'h1102, 1'b1, 2'd1);
        exp_flit("pri_f3", 3, 6, 16'h3300, 1'b0, 2'd3);
        exp_flit("pri_f4", 4, 7, 16'h3301, 1'b0, 2'd3);
        exp_flit("pri_f5", 5, 8, 16'h3302, 1'b1, 2'd3);
        check("pri_ir3_blocked", 64'(any_ir(3, 0, 4)), 64'd0);
        check("pri_bubble_busy", 64'(lg_busy[4]), 64'd0);
        check("pri_bubble_ov",   64'(lg_ov[5]),   64'd0);

        // No preemption: ch0 arrives while ch2 is mid-packet.
        restart(1'b1, 4'b0000, 4'b1111);
        load(2, 16'h2200, 4, 1'b1);
        drive();
        repeat (3) step();
        load(0, 16'h0A00, 1, 1'b1);
        drive();
        repeat (7) step();
        check("npe_count", 64'(outq.size()), 64'd5);
        exp_flit("npe_f0", 0, 2, 16'h2200, 1'b0, 2'd2);
        exp_flit("npe_f1", 1, 3, 16'h2201, 1'b0, 2'd2);
        exp_flit("npe_f2", 2, 4, 16'h2202, 1'b0, 2'd2);
        exp_flit("npe_f3", 3, 5, 16'h2203, 1'b1, 2'd2);
        exp_flit("npe_ch0", 4, 7, 16'h0A00, 1'b1, 2'd0);
        check("npe_ir0_blocked", 64'(any_ir(0, 3, 5)), 64'd0);

        // Single-channel mode: only ch2, then a mask with no requester.
        restart(1'b0, 4'b0100, 4'b1111);
        load(0, 16'h00A0, 2, 1'b1);
        load(1, 16'h00B0, 2, 1'b1);
        load(2, 16'h2C00, 2, 1'b1);
        drive();
        repeat (8) step();
        check("sgl_count", 64'(outq.size()), 64'd2);
        exp_flit("sgl_f0", 0, 2, 16'h2C00, 1'b0, 2'd2);
        exp_flit("sgl_f1", 1, 3, 16'h2C01, 1'b1, 2'd2);
        check("sgl_ir0", 64'(any_ir(0, 0, 7)), 64'd0);
        check("sgl_ir1", 64'(any_ir(1, 0, 7)), 64'd0);
        single_mask = 4'b1000;
        repeat (6) step();
        check("sgl_nogrant_busy", 64'(any_busy(8, 13)), 64'd0);
        check("sgl_nogrant_cnt", 64'(outq.size()), 64'd2);

        // Backpressure: out_ready 1,0,0,1 repeating.
        restart(1'b1, 4'b0000, 4'b1001);
        load(1, 16'h5500, 5, 1'b1);
        drive();
        repeat (16) step();
        check("bp_count", 64'(outq.size()), 64'd5);
        exp_flit("bp_f0", 0, 3,  16'h5500, 1'b0, 2'd1);
        exp_flit("bp_f1", 1, 4,  16'h5501, 1'b0, 2'd1);
        exp_flit("bp_f2", 2, 7,  16'h5502, 1'b0, 2'd1);
        exp_flit("bp_f3", 3, 8,  16'h5503, 1'b0, 2'd1);
        exp_flit("bp_f4", 4, 11, 16'h5504, 1'b1, 2'd1);
        check("bp_ir_full_c2", 64'(lg_ir[2][1]), 64'd0);
        check("bp_ir_full_c5", 64'(lg_ir[5][1]), 64'd0);
        check("bp_ir_free_c3", 64'(lg_ir[3][1]), 64'd1);
        check("bp_hold_data",  64'({lg_ov[6], lg_od[6]}), 64'h1_5502);

        // Length guard: 8 flits without last, MAX_FLITS = 6.
        restart(1'b1, 4'b0000, 4'b1111);
        load(0, 16'h0700, 8, 1'b0);
        drive();
        repeat (12) step();
        check("len_count", 64'(outq.size()), 64'd8);
        exp_flit("len_f4", 4, 6,  16'h0704, 1'b0, 2'd0);
        exp_flit("len_f5", 5, 7,  16'h0705, 1'b1, 2'd0);
        exp_flit("len_f6", 6, 9,  16'h0706, 1'b0, 2'd0);
        exp_flit("len_f7", 7, 10, 16'h0707, 1'b0, 2'd0);
        check("len_err_c6", 64'(lg_le[6]), 64'd0);
        check("len_err_c7", 64'(lg_le[7]), 64'd1);
        check("len_err_c8", 64'(lg_le[8]), 64'd0);
        check("len_idle_c7", 64'(lg_busy[7]), 64'd0);
        check("len_relock_c8", 64'(lg_busy[8]), 64'd1);

        // Reset in the middle of a 3-flit packet.
        restart(1'b1, 4'b0000, 4'b1111);
        load(2, 16'h6600, 3, 1'b1);
        drive();
        repeat (3) step();
        check("rmp_midpkt_busy", 64'(lg_busy[2]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rmp_ov",   64'(out_valid), 64'd0);
        check("rmp_ir",   64'(in_ready),  64'd0);
        check("rmp_busy", 64'(busy),      64'd0);
        for (int i = 0; i < N; i++) srcq[i].delete();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        outq.delete();
        out_ready = rdy_pat[0];
        load(2, 16'h6700, 3, 1'b1);
        drive();
        repeat (6) step();
        check("rmp_count", 64'(outq.size()), 64'd3);
        exp_flit("rmp_f0", 0, 2, 16'h6700, 1'b0, 2'd2);
        exp_flit("rmp_f1", 1, 3, 16'h6701, 1'b0, 2'd2);
        exp_flit("rmp_f2", 2, 4, 16'h6702, 1'b1, 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
